// File: rtl/chart_sequencer.sv
// Chart playback sequencer: paces row steps by difficulty, walks the chart ROM
// address and runs the countdown / play / pause / drain / done game flow.
module chart_sequencer #(
  parameter int ADDR_W          = 16,
  parameter int OFS_W           = 14,
  parameter int BASE_DIV        = 2000000,
  parameter int DIV_STEP        = 100000,
  parameter int DIV_W           = 24,
  parameter int COUNTDOWN_STEPS = 16,
  parameter int DRAIN_ROWS      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause_toggle,
  input  logic              abort,
  input  logic [1:0]        chart_select,
  input  logic [3:0]        sw_difficulty,
  input  logic [OFS_W-1:0]  chart_len,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              row_en,
  output logic              row_mask,
  output logic              game_state,
  output logic [2:0]        seq_state,
  output logic              done,
  output logic [OFS_W-1:0]  rows_left
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_DRAIN     = 3'd3,
    S_PAUSE     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam int PH_MAX = (COUNTDOWN_STEPS > DRAIN_ROWS) ? COUNTDOWN_STEPS : DRAIN_ROWS;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  CD_LAST  = PH_W'(COUNTDOWN_STEPS - 1);
  localparam logic [PH_W-1:0]  DR_LAST  = PH_W'(DRAIN_ROWS - 1);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [DIV_W-1:0] DIV_BASE = DIV_W'(BASE_DIV);
  localparam logic [DIV_W-1:0] DIV_DEC  = DIV_W'(DIV_STEP);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [OFS_W-1:0] OFS_ONE  = OFS_W'(1);

  state_t             r_state;
  state_t             r_saved;
  logic [DIV_W-1:0]   r_div;
  logic [OFS_W-1:0]   r_ofs;
  logic [PH_W-1:0]    r_phase;
  logic [1:0]         r_sel;
  logic [3:0]         r_diff;
  logic [OFS_W-1:0]   r_len;
  logic [OFS_W-1:0]   r_rows_left;
  logic               r_done;

  logic [DIV_W-1:0]   w_last;
  logic               w_running;
  logic               w_step;

  assign w_last    = DIV_BASE - (DIV_W'(r_diff) * DIV_DEC) - DIV_ONE;
  assign w_running = (r_state == S_COUNTDOWN) || (r_state == S_PLAY) || (r_state == S_DRAIN);
  // A pause or abort landing on the terminal divider count swallows that step.
  assign w_step    = w_running && (r_div == w_last) && !pause_toggle && !abort;

  assign row_en     = w_step;
  assign row_mask   = w_step && (r_state == S_PLAY);
  assign game_state = !w_running;
  assign seq_state  = r_state;
  assign done       = r_done;
  assign rows_left  = r_rows_left;
  assign rom_addr   = ADDR_W'({r_sel, r_ofs});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_saved     <= S_IDLE;
      r_div       <= '0;
      r_ofs       <= '0;
      r_phase     <= '0;
      r_sel       <= '0;
      r_diff      <= '0;
      r_len       <= '0;
      r_rows_left <= '0;
      r_done      <= 1'b0;
    end else if (abort) begin
      r_state     <= S_IDLE;
      r_saved     <= S_IDLE;
      r_div       <= '0;
      r_ofs       <= '0;
      r_phase     <= '0;
      r_sel       <= '0;
      r_diff      <= '0;
      r_len       <= '0;
      r_rows_left <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_sel       <= chart_select;
            r_diff      <= sw_difficulty;
            r_len       <= chart_len;
            r_rows_left <= chart_len;
            r_ofs       <= '0;
            r_div       <= '0;
            r_phase     <= '0;
            r_state     <= S_COUNTDOWN;
          end
        end
        S_PAUSE: begin
          if (pause_toggle) r_state <= r_saved;
        end
        S_COUNTDOWN, S_PLAY, S_DRAIN: begin
          if (pause_toggle) begin
            r_saved <= r_state;
            r_state <= S_PAUSE;
          end else if (r_div == w_last) begin
            r_div <= '0;
            case (r_state)
              S_COUNTDOWN: begin
                if (r_phase == CD_LAST) begin
                  r_phase <= '0;
                  r_state <= (r_len == '0) ? S_DRAIN : S_PLAY;
                end else begin
                  r_phase <= r_phase + PH_ONE;
                end
              end
              S_PLAY: begin
                r_rows_left <= r_rows_left - OFS_ONE;
                // Offset holds on the last row so the address stays inside this chart.
                if (r_ofs == r_len - OFS_ONE) r_state <= S_DRAIN;
                else                          r_ofs   <= r_ofs + OFS_ONE;
              end
              default: begin
                if (r_phase == DR_LAST) begin
                  r_phase <= '0;
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_phase <= r_phase + PH_ONE;
                end
              end
            endcase
          end else begin
            r_div <= r_div + DIV_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chart_sequencer.sv
// Scoreboard bench for chart_sequencer: stimulus queues expected row steps,
// a negedge monitor pops and checks every row_en the DUT presents.
module tb_chart_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause_toggle = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  chart_select = '0;
  logic [3:0]  sw_difficulty = '0;
  logic [3:0]  chart_len = '0;
  logic [15:0] rom_addr;
  logic        row_en;
  logic        row_mask;
  logic        game_state;
  logic [2:0]  seq_state;
  logic        done;
  logic [3:0]  rows_left;

  chart_sequencer #(
    .ADDR_W(16), .OFS_W(4), .BASE_DIV(20), .DIV_STEP(1), .DIV_W(24),
    .COUNTDOWN_STEPS(2), .DRAIN_ROWS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause_toggle(pause_toggle),
    .abort(abort), .chart_select(chart_select), .sw_difficulty(sw_difficulty),
    .chart_len(chart_len), .rom_addr(rom_addr), .row_en(row_en),
    .row_mask(row_mask), .game_state(game_state), .seq_state(seq_state),
    .done(done), .rows_left(rows_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit mask;
    int addr;
    int cyc;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Row n of a game: 2 countdown, len play, 3 drain rows; P cycles apart,
  // first one P-1 cycles after the capture edge; rows from pause_row on shifted by delay.
  task automatic push_game(input int t0, input int p, input int sel, input int len,
                           input int nmax, input int pause_row, input int delay);
    exp_t e;
    for (int n = 0; n < 2 + len + 3 && n < nmax; n++) begin
      e.mask = (n >= 2) && (n < 2 + len);
      e.addr = sel * 16 + (n - 2);
      e.cyc  = t0 + (n + 1) * p - 1 + ((n >= pause_row) ? delay : 0);
      q.push_back(e);
    end
  endtask

  task automatic do_start(input int sel, input int diff, input int len, output int t0);
    @(posedge clk); #1;
    chart_select  = sel[1:0];
    sw_difficulty = diff[3:0];
    chart_len     = len[3:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_until(input int t);
    if (cyc > t) chk("wait_target_passed", cyc, t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && row_en) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL row_unexpected: row_en at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("row_cycle", cyc, e.cyc);
        chk("row_mask", row_mask, e.mask);
        if (e.mask) chk("row_addr", rom_addr, e.addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seq_state", seq_state, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_row_en", row_en, 0);
    chk("rst_row_mask", row_mask, 0);
    chk("rst_game_state", game_state, 1);
    chk("rst_done", done, 0);
    chk("rst_rows_left", rows_left, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full game, diff 4 -> 16-cycle rows, chart 2 at addresses 32..36
    do_start(2, 4, 5, t0);
    push_game(t0, 16, 2, 5, 99, 99, 0);
    chk("t1_state_cd", seq_state, 1);
    chk("t1_running", game_state, 0);
    chk("t1_rows_left", rows_left, 5);
    chk("t1_addr_base", rom_addr, 32);
    wait_until(t0 + 160);
    chk("t1_done_pulse", done, 1);
    chk("t1_state_done", seq_state, 5);
    @(posedge clk); #1;
    chk("t1_done_single", done, 0);
    chk("t1_state_hold", seq_state, 5);
    chk("t1_game_state", game_state, 1);
    chk("t1_rows_left_end", rows_left, 0);

    // Pause on the terminal divider count at addr 33, resume 11 cycles later
    do_start(2, 4, 5, t0);
    push_game(t0, 16, 2, 5, 99, 3, 12);
    wait_until(t0 + 63);
    chk("t2_addr_before", rom_addr, 33);
    pause_toggle = 1'b1;
    @(posedge clk); #1;
    pause_toggle = 1'b0;
    chk("t2_state_pause", seq_state, 4);
    chk("t2_game_state", game_state, 1);
    wait_until(t0 + 74);
    chk("t2_addr_paused", rom_addr, 33);
    pause_toggle = 1'b1;
    @(posedge clk); #1;
    pause_toggle = 1'b0;
    chk("t2_state_resume", seq_state, 2);
    wait_until(t0 + 172);
    chk("t2_done_pulse", done, 1);

    // Empty chart, diff 0 -> 20-cycle rows, straight from countdown to drain
    do_start(1, 0, 0, t0);
    push_game(t0, 20, 1, 0, 99, 99, 0);
    wait_until(t0 + 40);
    chk("t3_state_drain", seq_state, 3);
    wait_until(t0 + 100);
    chk("t3_done_pulse", done, 1);
    chk("t3_state_done", seq_state, 5);

    // Abort together with pause mid-play, then restart from offset 0
    do_start(2, 4, 5, t0);
    push_game(t0, 16, 2, 5, 3, 99, 0);
    wait_until(t0 + 50);
    chk("t4_state_play", seq_state, 2);
    abort = 1'b1;
    pause_toggle = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    pause_toggle = 1'b0;
    chk("t4_state_idle", seq_state, 0);
    chk("t4_rom_addr", rom_addr, 0);
    chk("t4_game_state", game_state, 1);
    chk("t4_rows_left", rows_left, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("t4_still_idle", seq_state, 0);
    do_start(2, 4, 5, t0);
    push_game(t0, 16, 2, 5, 99, 99, 0);
    chk("t4_restart_addr", rom_addr, 32);
    chk("t4_restart_rows", rows_left, 5);

    // start during play is ignored; pause_toggle in IDLE is ignored
    wait_until(t0 + 50);
    chk("t5_addr_before", rom_addr, 33);
    chart_select = 2'd1;
    sw_difficulty = 4'd0;
    chart_len = 4'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_state_play", seq_state, 2);
    chk("t5_addr_kept", rom_addr, 33);
    chk("t5_rows_kept", rows_left, 4);
    wait_until(t0 + 160);
    chk("t5_done_pulse", done, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_idle", seq_state, 0);
    pause_toggle = 1'b1;
    @(posedge clk); #1;
    pause_toggle = 1'b0;
    chk("t5_pause_ignored", seq_state, 0);
    chk("t5_game_state", game_state, 1);
    repeat (40) @(posedge clk);
    #1;
    chk("t5_idle_hold", seq_state, 0);

    // Asynchronous reset mid-drain
    do_start(2, 4, 5, t0);
    push_game(t0, 16, 2, 5, 8, 99, 0);
    wait_until(t0 + 130);
    chk("t6_state_drain", seq_state, 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_seq_state", seq_state, 0);
    chk("t6_rom_addr", rom_addr, 0);
    chk("t6_row_en", row_en, 0);
    chk("t6_row_mask", row_mask, 0);
    chk("t6_game_state", game_state, 1);
    chk("t6_done", done, 0);
    chk("t6_rows_left", rows_left, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_held_idle", seq_state, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_idle_after", seq_state, 0);
    chk("t6_no_row", row_en, 0);

    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
